regfile: RTL and testbench

Architectural register file at the write-back end of the five-stage pipeline: consumes the write port driven by the MEM/WB pipeline register (address, data, enable) and serves the two combinational read ports used by the decode stage. Also holds the HI/LO special registers written at write-back. Same-cycle write-to-read bypass lets decode see a value retiring in the same cycle with no extra forwarding stage.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_if.sv | 36 +++
 rtl/regfile_hilo_reg.sv | 46 ++++
 rtl/regfile.sv | 72 +++++++
 tb/tb_regfile.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defines and types for the architectural register file.
package regfile_pkg;

   localparam int unsigned N_REG        = 32;
   localparam int unsigned N_REG_ADDR   = 5;
   localparam logic        RST_ENABLE    = 1'b0;
   localparam logic        WRITE_ENABLE  = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;
   localparam logic [N_REG_ADDR-1:0] NOP_REG_ADDR = '0;

   typedef logic [N_REG-1:0]      word_t;
   typedef logic [N_REG_ADDR-1:0] reg_addr_t;

   // Write-back payload as carried by the MEM/WB pipeline register.
   typedef struct packed {
      logic      wen;
      reg_addr_t waddr;
      word_t     wdata;
   } wb_req_t;

endpackage

// File: rtl/regfile_if.sv
// Write-back, decode read and HI/LO signals of the register file.
interface regfile_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] i_wb_waddr;
   logic [DATA_W-1:0] i_wb_wdata;
   logic              i_wb_wen;
   logic              i_re1;
   logic              i_re2;
   logic [ADDR_W-1:0] i_raddr1;
   logic [ADDR_W-1:0] i_raddr2;
   logic [DATA_W-1:0] o_rdata1;
   logic [DATA_W-1:0] o_rdata2;
   logic              i_hilo_wen;
   logic [DATA_W-1:0] i_hi;
   logic [DATA_W-1:0] i_lo;
   logic [DATA_W-1:0] o_hi;
   logic [DATA_W-1:0] o_lo;

   modport slave (
      input  i_wb_waddr, i_wb_wdata, i_wb_wen,
      input  i_re1, i_re2, i_raddr1, i_raddr2,
      output o_rdata1, o_rdata2,
      input  i_hilo_wen, i_hi, i_lo,
      output o_hi, o_lo
   );

   modport master (
      output i_wb_waddr, i_wb_wdata, i_wb_wen,
      output i_re1, i_re2, i_raddr1, i_raddr2,
      input  o_rdata1, o_rdata2,
      output i_hilo_wen, i_hi, i_lo,
      input  o_hi, o_lo
   );
endinterface

// File: rtl/regfile_hilo_reg.sv
// HI/LO special registers written together at write-back.
module hilo_reg
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = N_REG,
   parameter int unsigned BYPASS = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wen,
   input  logic [DATA_W-1:0] i_hi,
   input  logic [DATA_W-1:0] i_lo,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);

   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;

   // Both halves update in the same cycle, never one without the other.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (i_rst_n == RST_ENABLE) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (i_wen == WRITE_ENABLE) begin
         hi_q <= i_hi;
         lo_q <= i_lo;
      end
   end

   // Present retiring HI/LO in the same cycle when forwarding is enabled.
   always_comb begin
      o_hi = '0;
      o_lo = '0;
      if (i_rst_n != RST_ENABLE) begin
         if ((BYPASS != 0) && (i_wen == WRITE_ENABLE)) begin
            o_hi = i_hi;
            o_lo = i_lo;
         end else begin
            o_hi = hi_q;
            o_lo = lo_q;
         end
      end
   end

endmodule

// File: rtl/regfile.sv
// Architectural GPR file with two combinational read ports and HI/LO.
module regfile
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = N_REG,
   parameter int unsigned ADDR_W = N_REG_ADDR,
   parameter int unsigned BYPASS = 1
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   regfile_if.slave  bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] R0 = ADDR_W'(NOP_REG_ADDR);

   logic [DATA_W-1:0] gpr [DEPTH];
   logic              wr_go_c;
   logic              byp1_c;
   logic              byp2_c;

   // r0 is hardwired to zero, so writes aimed at it are dropped here.
   assign wr_go_c = (bus.i_wb_wen == WRITE_ENABLE) && (bus.i_wb_waddr != R0);
   assign byp1_c  = (BYPASS != 0) && (bus.i_wb_wen == WRITE_ENABLE) &&
                    (bus.i_wb_waddr == bus.i_raddr1);
   assign byp2_c  = (BYPASS != 0) && (bus.i_wb_wen == WRITE_ENABLE) &&
                    (bus.i_wb_waddr == bus.i_raddr2);

   // GPR array: async clear, one write per cycle from MEM/WB.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (i_rst_n == RST_ENABLE) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            gpr[i] <= '0;
         end
      end else if (wr_go_c) begin
         gpr[bus.i_wb_waddr] <= bus.i_wb_wdata;
      end
   end

   // Read port 1: reset, disable and r0 force zero; then forward, then array.
   always_comb begin
      bus.o_rdata1 = '0;
      if ((i_rst_n != RST_ENABLE) && bus.i_re1 && (bus.i_raddr1 != R0)) begin
         if (byp1_c) bus.o_rdata1 = bus.i_wb_wdata;
         else        bus.o_rdata1 = gpr[bus.i_raddr1];
      end
   end

   // Read port 2: same priority as port 1, fully independent.
   always_comb begin
      bus.o_rdata2 = '0;
      if ((i_rst_n != RST_ENABLE) && bus.i_re2 && (bus.i_raddr2 != R0)) begin
         if (byp2_c) bus.o_rdata2 = bus.i_wb_wdata;
         else        bus.o_rdata2 = gpr[bus.i_raddr2];
      end
   end

   // HI/LO share the same reset and forwarding rules as the GPRs.
   hilo_reg #(
      .DATA_W (DATA_W),
      .BYPASS (BYPASS)
   ) u_hilo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wen   (bus.i_hilo_wen),
      .i_hi    (bus.i_hi),
      .i_lo    (bus.i_lo),
      .o_hi    (bus.o_hi),
      .o_lo    (bus.o_lo)
   );

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: one forwarding instance and one without.
module tb_regfile;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   regfile_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
   regfile_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

   regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_b)
   );

   regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_n (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus_b.i_wb_wen = 1'b0; bus_b.i_wb_waddr = '0; bus_b.i_wb_wdata = '0;
      bus_b.i_re1 = 1'b0; bus_b.i_re2 = 1'b0; bus_b.i_raddr1 = '0; bus_b.i_raddr2 = '0;
      bus_b.i_hilo_wen = 1'b0; bus_b.i_hi = '0; bus_b.i_lo = '0;
      bus_n.i_wb_wen = 1'b0; bus_n.i_wb_waddr = '0; bus_n.i_wb_wdata = '0;
      bus_n.i_re1 = 1'b0; bus_n.i_re2 = 1'b0; bus_n.i_raddr1 = '0; bus_n.i_raddr2 = '0;
      bus_n.i_hilo_wen = 1'b0; bus_n.i_hi = '0; bus_n.i_lo = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      bus_b.i_re1 = 1'b1; bus_b.i_re2 = 1'b1;
      bus_b.i_raddr1 = 5'd3; bus_b.i_raddr2 = 5'd31;
      bus_b.i_hilo_wen = 1'b1; bus_b.i_hi = 32'h1; bus_b.i_lo = 32'h2;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rd1 got=%h exp=%h", bus_b.o_rdata1, 32'h0); end
      total++; if (bus_b.o_rdata2 !== 32'h0) begin bad++; $display("FAIL reset_rd2 got=%h exp=%h", bus_b.o_rdata2, 32'h0); end
      total++; if (bus_b.o_hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", bus_b.o_hi, 32'h0); end
      total++; if (bus_b.o_lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", bus_b.o_lo, 32'h0); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus_b.i_hilo_wen = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         bus_b.i_raddr1 = 5'(i);
         bus_b.i_raddr2 = 5'(31 - i);
         #1;
         total++; if (bus_b.o_rdata1 !== 32'h0) begin bad++; $display("FAIL post_reset_rd1 r%0d got=%h exp=%h", i, bus_b.o_rdata1, 32'h0); end
         total++; if (bus_b.o_rdata2 !== 32'h0) begin bad++; $display("FAIL post_reset_rd2 r%0d got=%h exp=%h", 31 - i, bus_b.o_rdata2, 32'h0); end
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      bus_b.i_re1 = 1'b0; bus_b.i_re2 = 1'b0;
      bus_b.i_wb_wen = 1'b1; bus_b.i_wb_waddr = 5'd5; bus_b.i_wb_wdata = 32'hDEADBEEF;
      @(negedge clk);
      bus_b.i_wb_wen = 1'b0; bus_b.i_wb_waddr = 'x; bus_b.i_wb_wdata = 'x;
      bus_b.i_re1 = 1'b1; bus_b.i_raddr1 = 5'd5;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd r5 got=%h exp=%h", bus_b.o_rdata1, 32'hDEADBEEF); end
      bus_b.i_re1 = 1'b0;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h0) begin bad++; $display("FAIL re1_off got=%h exp=%h", bus_b.o_rdata1, 32'h0); end
      // X on address/data with wen low across an edge must not disturb r5
      @(negedge clk);
      bus_b.i_re1 = 1'b1;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL x_no_corrupt got=%h exp=%h", bus_b.o_rdata1, 32'hDEADBEEF); end
      bus_b.i_wb_waddr = '0; bus_b.i_wb_wdata = '0;
   endtask

   task automatic test_bypass();
      @(negedge clk);
      bus_b.i_wb_wen = 1'b1; bus_b.i_wb_waddr = 5'd7; bus_b.i_wb_wdata = 32'h12345678;
      bus_b.i_re1 = 1'b1; bus_b.i_re2 = 1'b1; bus_b.i_raddr1 = 5'd7; bus_b.i_raddr2 = 5'd7;
      bus_n.i_wb_wen = 1'b1; bus_n.i_wb_waddr = 5'd7; bus_n.i_wb_wdata = 32'h11111111;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h12345678) begin bad++; $display("FAIL byp_rd1 got=%h exp=%h", bus_b.o_rdata1, 32'h12345678); end
      total++; if (bus_b.o_rdata2 !== 32'h12345678) begin bad++; $display("FAIL byp_rd2 got=%h exp=%h", bus_b.o_rdata2, 32'h12345678); end
      // write to r8 must not be forwarded onto a read of r7
      @(negedge clk);
      bus_b.i_wb_waddr = 5'd8; bus_b.i_wb_wdata = 32'h0000AAAA;
      bus_n.i_wb_wdata = 32'h12345678;
      bus_n.i_re1 = 1'b1; bus_n.i_re2 = 1'b1; bus_n.i_raddr1 = 5'd7; bus_n.i_raddr2 = 5'd7;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h12345678) begin bad++; $display("FAIL byp_addr_miss got=%h exp=%h", bus_b.o_rdata1, 32'h12345678); end
      total++; if (bus_n.o_rdata1 !== 32'h11111111) begin bad++; $display("FAIL nobyp_rd1_old got=%h exp=%h", bus_n.o_rdata1, 32'h11111111); end
      total++; if (bus_n.o_rdata2 !== 32'h11111111) begin bad++; $display("FAIL nobyp_rd2_old got=%h exp=%h", bus_n.o_rdata2, 32'h11111111); end
      @(negedge clk);
      bus_b.i_wb_wen = 1'b0;
      bus_n.i_wb_wen = 1'b0;
      bus_b.i_raddr2 = 5'd8;
      #1;
      total++; if (bus_n.o_rdata1 !== 32'h12345678) begin bad++; $display("FAIL nobyp_rd1_new got=%h exp=%h", bus_n.o_rdata1, 32'h12345678); end
      total++; if (bus_n.o_rdata2 !== 32'h12345678) begin bad++; $display("FAIL nobyp_rd2_new got=%h exp=%h", bus_n.o_rdata2, 32'h12345678); end
      total++; if (bus_b.o_rdata2 !== 32'h0000AAAA) begin bad++; $display("FAIL r8_stored got=%h exp=%h", bus_b.o_rdata2, 32'h0000AAAA); end
   endtask

   task automatic test_r0();
      @(negedge clk);
      bus_b.i_wb_wen = 1'b1; bus_b.i_wb_waddr = 5'd0; bus_b.i_wb_wdata = 32'hFFFFFFFF;
      bus_b.i_re1 = 1'b1; bus_b.i_re2 = 1'b1; bus_b.i_raddr1 = 5'd0; bus_b.i_raddr2 = 5'd0;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h0) begin bad++; $display("FAIL r0_byp_rd1 got=%h exp=%h", bus_b.o_rdata1, 32'h0); end
      total++; if (bus_b.o_rdata2 !== 32'h0) begin bad++; $display("FAIL r0_byp_rd2 got=%h exp=%h", bus_b.o_rdata2, 32'h0); end
      @(negedge clk);
      bus_b.i_wb_wen = 1'b0;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h0) begin bad++; $display("FAIL r0_next_rd1 got=%h exp=%h", bus_b.o_rdata1, 32'h0); end
      total++; if (bus_b.o_rdata2 !== 32'h0) begin bad++; $display("FAIL r0_next_rd2 got=%h exp=%h", bus_b.o_rdata2, 32'h0); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus_b.i_wb_wen = 1'b1; bus_b.i_wb_waddr = 5'd9; bus_b.i_wb_wdata = 32'h1;
      @(negedge clk);
      bus_b.i_wb_wdata = 32'h2;
      bus_b.i_re1 = 1'b1; bus_b.i_raddr1 = 5'd9;
      bus_b.i_re2 = 1'b1; bus_b.i_raddr2 = 5'd5;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h2) begin bad++; $display("FAIL b2b_byp got=%h exp=%h", bus_b.o_rdata1, 32'h2); end
      total++; if (bus_b.o_rdata2 !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_other_port got=%h exp=%h", bus_b.o_rdata2, 32'hDEADBEEF); end
      @(negedge clk);
      bus_b.i_wb_wdata = 32'h3;
      @(negedge clk);
      bus_b.i_wb_wen = 1'b0;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h3) begin bad++; $display("FAIL b2b_last got=%h exp=%h", bus_b.o_rdata1, 32'h3); end
   endtask

   task automatic test_hilo();
      @(negedge clk);
      bus_b.i_hilo_wen = 1'b1; bus_b.i_hi = 32'hA; bus_b.i_lo = 32'hB;
      bus_n.i_hilo_wen = 1'b1; bus_n.i_hi = 32'hA; bus_n.i_lo = 32'hB;
      #1;
      total++; if (bus_b.o_hi !== 32'hA) begin bad++; $display("FAIL hi_byp got=%h exp=%h", bus_b.o_hi, 32'hA); end
      total++; if (bus_b.o_lo !== 32'hB) begin bad++; $display("FAIL lo_byp got=%h exp=%h", bus_b.o_lo, 32'hB); end
      total++; if (bus_n.o_hi !== 32'h0) begin bad++; $display("FAIL hi_nobyp_old got=%h exp=%h", bus_n.o_hi, 32'h0); end
      @(negedge clk);
      bus_b.i_hilo_wen = 1'b0; bus_b.i_hi = 32'h55; bus_b.i_lo = 32'h66;
      bus_n.i_hilo_wen = 1'b0; bus_n.i_hi = 32'h55; bus_n.i_lo = 32'h66;
      #1;
      total++; if (bus_b.o_hi !== 32'hA) begin bad++; $display("FAIL hi_hold got=%h exp=%h", bus_b.o_hi, 32'hA); end
      total++; if (bus_b.o_lo !== 32'hB) begin bad++; $display("FAIL lo_hold got=%h exp=%h", bus_b.o_lo, 32'hB); end
      total++; if (bus_n.o_lo !== 32'hB) begin bad++; $display("FAIL lo_nobyp_new got=%h exp=%h", bus_n.o_lo, 32'hB); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus_b.o_hi !== 32'h0) begin bad++; $display("FAIL hi_rst got=%h exp=%h", bus_b.o_hi, 32'h0); end
      total++; if (bus_b.o_lo !== 32'h0) begin bad++; $display("FAIL lo_rst got=%h exp=%h", bus_b.o_lo, 32'h0); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (bus_b.o_hi !== 32'h0) begin bad++; $display("FAIL hi_after_rst got=%h exp=%h", bus_b.o_hi, 32'h0); end
      total++; if (bus_n.o_lo !== 32'h0) begin bad++; $display("FAIL lo_after_rst got=%h exp=%h", bus_n.o_lo, 32'h0); end
   endtask

   task automatic test_reset_mid();
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         bus_b.i_wb_wen = 1'b1; bus_b.i_wb_waddr = 5'(i); bus_b.i_wb_wdata = 32'h100 + 32'(i);
      end
      @(negedge clk);
      bus_b.i_wb_wen = 1'b0;
      bus_b.i_re1 = 1'b1; bus_b.i_re2 = 1'b1; bus_b.i_raddr1 = 5'd1; bus_b.i_raddr2 = 5'd31;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h101) begin bad++; $display("FAIL fill_r1 got=%h exp=%h", bus_b.o_rdata1, 32'h101); end
      total++; if (bus_b.o_rdata2 !== 32'h11F) begin bad++; $display("FAIL fill_r31 got=%h exp=%h", bus_b.o_rdata2, 32'h11F); end
      // reset lands between edges and stays low across a posedge carrying a write
      @(negedge clk);
      bus_b.i_wb_wen = 1'b1; bus_b.i_wb_waddr = 5'd4; bus_b.i_wb_wdata = 32'hCAFE;
      bus_b.i_raddr1 = 5'd4; bus_b.i_raddr2 = 5'd20;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h0) begin bad++; $display("FAIL rst_mid_rd1 got=%h exp=%h", bus_b.o_rdata1, 32'h0); end
      total++; if (bus_b.o_rdata2 !== 32'h0) begin bad++; $display("FAIL rst_mid_rd2 got=%h exp=%h", bus_b.o_rdata2, 32'h0); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus_b.i_wb_wen = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bus_b.i_raddr1 = 5'(i);
         bus_b.i_raddr2 = 5'(31 - i);
         #1;
         total++; if (bus_b.o_rdata1 !== 32'h0) begin bad++; $display("FAIL rst_clear_rd1 r%0d got=%h exp=%h", i, bus_b.o_rdata1, 32'h0); end
         total++; if (bus_b.o_rdata2 !== 32'h0) begin bad++; $display("FAIL rst_clear_rd2 r%0d got=%h exp=%h", 31 - i, bus_b.o_rdata2, 32'h0); end
      end
      @(posedge clk);
      @(negedge clk);
      bus_b.i_raddr1 = 5'd4;
      #1;
      total++; if (bus_b.o_rdata1 !== 32'h0) begin bad++; $display("FAIL rst_write_lost got=%h exp=%h", bus_b.o_rdata1, 32'h0); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_write_read();
      test_bypass();
      test_r0();
      test_back_to_back();
      test_hilo();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
